// File: rtl/raizing_pal_fade.sv
// Palette output stage: palette lookup, per-component 8-bit expansion, frame-synchronous fade, blanking.
// Optional half-intensity shadow input is enabled by defining RAIZING_PAL_SHADOW_EN.
module raizing_pal_fade #(
    parameter int AW              = 11,
    parameter int DW              = 16,
    parameter int CW              = 5,
    parameter int LW              = 5,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PIXEL_CEN,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [AW-1:0] PIXEL,
`ifdef RAIZING_PAL_SHADOW_EN
    input  logic          SHADOW,
`endif
    output logic [AW-1:0] PAL_ADDR,
    input  logic [DW-1:0] PAL_DATA,
    input  logic          FADE_REQ,
    input  logic          FADE_DIR,
    output logic          FADE_BUSY,
    output logic          FADE_DONE,
    output logic          LHBL_DLY,
    output logic          LVBL_DLY,
    output logic [7:0]    RED,
    output logic [7:0]    GREEN,
    output logic [7:0]    BLUE
);

    localparam int CNTW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAMES_PER_STEP - 1);
    localparam logic [LW:0] LVL_FULL = {1'b1, {LW{1'b0}}};
    localparam logic [LW:0] LVL_ONE  = {{LW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [AW-1:0]   pal_addr_reg;
    logic [2:0]      lhbl_sr_reg;
    logic [2:0]      lvbl_sr_reg;
    logic [23:0]     c8_next;
    logic [23:0]     c8_reg;
    logic [23:0]     f_next;
    logic [23:0]     rgb_reg;
    logic [1:0]      state_reg, state_next;
    logic            dir_reg, dir_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [LW:0]     lvl_reg, lvl_next;
    logic            frame_tick;
    logic            shadow_s2;
    logic            unused_pal_data;

    assign unused_pal_data = ^PAL_DATA;

`ifdef RAIZING_PAL_SHADOW_EN
    logic shadow_s1_reg;
    logic shadow_s2_reg;

    // Shadow bit travels with its pixel through the first two stages.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_s1_reg <= 1'b0;
            shadow_s2_reg <= 1'b0;
        end else if (PIXEL_CEN) begin
            shadow_s1_reg <= SHADOW;
            shadow_s2_reg <= shadow_s1_reg;
        end
    end
    assign shadow_s2 = shadow_s2_reg;
`else
    assign shadow_s2 = 1'b0;
`endif

    // Expansion replicates the component MSBs into the low bits so full scale maps to 8'hFF.
    for (genvar gi = 0; gi < 3; gi++) begin : g_comp
        logic [CW-1:0]   comp;
        logic [8+LW:0]   prod;
        logic [7:0]      scaled;
        logic            unused_prod;

        assign comp = PAL_DATA[gi*CW +: CW];
        if (CW == 8) begin : g_pass
            assign c8_next[gi*8 +: 8] = comp;
        end else begin : g_expand
            assign c8_next[gi*8 +: 8] = {comp, comp[CW-1 -: 8-CW]};
        end

        assign prod        = {{(LW+1){1'b0}}, c8_reg[gi*8 +: 8]} * {8'b0, lvl_reg};
        assign scaled      = prod[LW +: 8];
        assign unused_prod = ^{prod[8+LW], prod[LW-1:0]};
        assign f_next[gi*8 +: 8] = shadow_s2 ? {1'b0, scaled[7:1]} : scaled;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pal_addr_reg <= '0;
            lhbl_sr_reg  <= '0;
            lvbl_sr_reg  <= '0;
            c8_reg       <= '0;
            rgb_reg      <= '0;
        end else if (PIXEL_CEN) begin
            pal_addr_reg <= PIXEL;
            lhbl_sr_reg  <= {lhbl_sr_reg[1:0], LHBL};
            lvbl_sr_reg  <= {lvbl_sr_reg[1:0], LVBL};
            c8_reg       <= c8_next;
            // Gate with the blanking bits that become LHBL_DLY/LVBL_DLY on this same edge.
            rgb_reg      <= (lhbl_sr_reg[1] & lvbl_sr_reg[1]) ? f_next : 24'd0;
        end
    end

    // lvbl_sr_reg[0] holds LVBL as sampled on the previous pixel enable.
    assign frame_tick = PIXEL_CEN & lvbl_sr_reg[0] & ~LVBL;

    always_comb begin
        logic [LW:0] step_lvl;
        logic [LW:0] run_target;
        logic [LW:0] req_target;
        state_next = state_reg;
        dir_next   = dir_reg;
        cnt_next   = cnt_reg;
        lvl_next   = lvl_reg;
        run_target = dir_reg ? '0 : LVL_FULL;
        req_target = FADE_DIR ? '0 : LVL_FULL;
        step_lvl   = dir_reg ? (lvl_reg - LVL_ONE) : (lvl_reg + LVL_ONE);
        case (state_reg)
            ST_IDLE: begin
                if (FADE_REQ) begin
                    dir_next   = FADE_DIR;
                    cnt_next   = '0;
                    state_next = (lvl_reg == req_target) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        lvl_next = step_lvl;
                        if (step_lvl == run_target) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNTW'(1);
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            dir_reg   <= 1'b0;
            cnt_reg   <= '0;
            lvl_reg   <= LVL_FULL;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            cnt_reg   <= cnt_next;
            lvl_reg   <= lvl_next;
        end
    end

    assign PAL_ADDR  = pal_addr_reg;
    assign LHBL_DLY  = lhbl_sr_reg[2];
    assign LVBL_DLY  = lvbl_sr_reg[2];
    assign RED       = rgb_reg[7:0];
    assign GREEN     = rgb_reg[15:8];
    assign BLUE      = rgb_reg[23:16];
    assign FADE_BUSY = (state_reg == ST_RUN);
    assign FADE_DONE = (state_reg == ST_DONE);

endmodule

// File: tb/tb_raizing_pal_fade.sv
// Directed scoreboard bench for raizing_pal_fade: pixel pipeline, blanking alignment, fade FSM, reset abort.
module tb_raizing_pal_fade;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_cen = 1'b0;
    logic        lhbl = 1'b0;
    logic        lvbl = 1'b0;
    logic [10:0] pixel = '0;
    logic [10:0] pal_addr;
    logic [15:0] pal_data;
    logic        fade_req = 1'b0;
    logic        fade_dir = 1'b0;
    logic        fade_busy, fade_done, lhbl_dly, lvbl_dly;
    logic [7:0]  red, green, blue;
`ifdef RAIZING_PAL_SHADOW_EN
    logic        shadow = 1'b0;
`endif

    always #5 clk = ~clk;

    raizing_pal_fade dut (
        .CLK(clk), .RESET(reset), .PIXEL_CEN(pixel_cen), .LHBL(lhbl), .LVBL(lvbl),
        .PIXEL(pixel),
`ifdef RAIZING_PAL_SHADOW_EN
        .SHADOW(shadow),
`endif
        .PAL_ADDR(pal_addr), .PAL_DATA(pal_data), .FADE_REQ(fade_req), .FADE_DIR(fade_dir),
        .FADE_BUSY(fade_busy), .FADE_DONE(fade_done), .LHBL_DLY(lhbl_dly), .LVBL_DLY(lvbl_dly),
        .RED(red), .GREEN(green), .BLUE(blue)
    );

    logic [15:0] pal [0:15];
    assign pal_data = pal[pal_addr[3:0]];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [25:0] sb_q[$];

    // Reference fade state, advanced from the stimulus alone.
    int   lvl_m = 32;
    bit   run_m = 0;
    bit   dir_m = 0;
    int   cnt_m = 0;
    logic prev_vb = 1'b0;

    always @(posedge clk) begin
        if (fade_done) done_cnt++;
        if (fade_busy) busy_cnt++;
    end

    function automatic logic [7:0] exp8(input logic [4:0] c);
        logic [7:0] r;
        r = {c, c[4:2]};
        return r;
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] c, input int lv);
        int p;
        p = (int'(c) * lv) >> 5;
        return p[7:0];
    endfunction

    function automatic logic [25:0] model(input int idx, input logic hb, input logic vb, input int lv);
        logic [15:0] d;
        d = pal[idx];
        if (hb && vb)
            return {hb, vb, scale(exp8(d[4:0]), lv), scale(exp8(d[9:5]), lv), scale(exp8(d[14:10]), lv)};
        return {hb, vb, 24'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_tick();
        if (run_m) begin
            if (cnt_m == 1) begin
                cnt_m = 0;
                lvl_m = dir_m ? lvl_m - 1 : lvl_m + 1;
                if (lvl_m == (dir_m ? 0 : 32)) run_m = 0;
            end else begin
                cnt_m++;
            end
        end
    endtask

    task automatic pix(input int idx, input logic hb, input logic vb, input string tag);
        logic [25:0] e;
        repeat (2) @(negedge clk);
        pixel_cen = 1'b1;
        pixel = 11'(idx);
        lhbl = hb;
        lvbl = vb;
        if (prev_vb && !vb) model_tick();
        prev_vb = vb;
        sb_q.push_back(model(idx, hb, vb, lvl_m));
        @(posedge clk);
        #1;
        pixel_cen = 1'b0;
        if (sb_q.size() >= 3) begin
            e = sb_q.pop_front();
            check(tag, {6'd0, lhbl_dly, lvbl_dly, red, green, blue}, {6'd0, e});
            $display("[TB] pix %s rgb=%02h/%02h/%02h dly=%b%b", tag, red, green, blue, lhbl_dly, lvbl_dly);
        end
    endtask

    task automatic frame(input string tag);
        pix(0, 1'b1, 1'b1, tag);
        pix(4, 1'b1, 1'b1, tag);
        repeat (3) pix(5, 1'b0, 1'b1, tag);
        repeat (2) pix(5, 1'b0, 1'b0, tag);
    endtask

    task automatic req(input logic dir);
        @(negedge clk);
        fade_req = 1'b1;
        fade_dir = dir;
        if (lvl_m != (dir ? 0 : 32)) begin
            run_m = 1;
            dir_m = dir;
            cnt_m = 0;
        end
        @(posedge clk);
        #1;
        fade_req = 1'b0;
        $display("[TB] fade_req dir=%0b busy=%0b done=%0b", dir, fade_busy, fade_done);
    endtask

    initial begin
        pal[0] = 16'h7FFF; pal[1] = 16'h0010; pal[2] = 16'h03E0; pal[3] = 16'h7C00;
        pal[4] = 16'h2A55; pal[5] = 16'h0000;
        for (int i = 6; i < 16; i++) pal[i] = 16'h1234;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pal_addr", {21'd0, pal_addr}, 32'd0);
        check("rst_rgb", {8'd0, red, green, blue}, 32'd0);
        check("rst_busy", {31'd0, fade_busy}, 32'd0);
        check("rst_done", {31'd0, fade_done}, 32'd0);
        check("rst_dly", {30'd0, lhbl_dly, lvbl_dly}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic datapath and blanking alignment at full brightness.
        pix(0, 1'b1, 1'b1, "white");
        pix(1, 1'b1, 1'b1, "red10");
        check("pal_addr", {21'd0, pal_addr}, 32'd1);
        pix(2, 1'b1, 1'b1, "green");
        pix(3, 1'b1, 1'b1, "blue");
        pix(1, 1'b0, 1'b1, "hblank");
        pix(4, 1'b1, 1'b1, "mix");
        pix(0, 1'b1, 1'b0, "vblank");
        pix(0, 1'b1, 1'b1, "white2");
        repeat (2) pix(5, 1'b0, 1'b1, "flush");

        // Fade-in request while already full: immediate done, never busy.
        done_cnt = 0;
        busy_cnt = 0;
        req(1'b0);
        check("noop_done", {31'd0, fade_done}, 32'd1);
        check("noop_busy", {31'd0, fade_busy}, 32'd0);
        @(posedge clk);
        #1;
        check("noop_done_end", {31'd0, fade_done}, 32'd0);
        check("noop_pulses", done_cnt, 32'd1);
        check("noop_busy_cnt", busy_cnt, 32'd0);
        frame("noop_frame");

        // Fade out to black over 64 frame ticks.
        done_cnt = 0;
        req(1'b1);
        check("out_busy", {31'd0, fade_busy}, 32'd1);
        for (int f = 0; f < 63; f++) frame("fade_out");
        check("out_done_early", done_cnt, 32'd0);
        check("out_busy_mid", {31'd0, fade_busy}, 32'd1);
        frame("fade_out_last");
        check("out_done_once", done_cnt, 32'd1);
        check("out_busy_end", {31'd0, fade_busy}, 32'd0);
        frame("black");
        frame("black2");

        // Fade back in partway, then reset mid-fade at level 10.
        req(1'b0);
        for (int f = 0; f < 20; f++) frame("fade_in");
        repeat (4) pix(0, 1'b1, 1'b1, "lvl10");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'd0, fade_busy}, 32'd0);
        check("mid_rst_rgb", {8'd0, red, green, blue}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        lvl_m = 32;
        run_m = 0;
        cnt_m = 0;
        prev_vb = 1'b0;
        frame("post_rst");
        frame("post_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
